// File: rtl/clave_pkg.sv
// Shared types and constants for the clave pattern sequencer.
package clave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_HOLD,
        ST_WRAP
    } state_t;

    localparam int unsigned NUM_BEATS       = 5;
    localparam logic [12:0] BAR_LEN_DEFAULT = 13'd6600;

    // Count positions of the five clave hits within one bar.
    localparam logic [12:0] BEAT_POS [NUM_BEATS] = '{
        13'd0, 13'd1200, 13'd2400, 13'd4000, 13'd4800
    };

    // Position of hit idx; zero for indices past the last hit.
    function automatic logic [12:0] beat_pos(input logic [2:0] idx);
        logic [12:0] pos;
        pos = '0;
        for (int unsigned i = 0; i < NUM_BEATS; i++) begin
            if (idx == 3'(i)) pos = BEAT_POS[i];
        end
        return pos;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts 0..TICK_DIV-1 while run is high, holds otherwise.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // Next prescaler value: clear wins, otherwise wrap at LAST while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
        end
    end

    assign tick = run && !clear && (cnt_q == LAST);

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clave_sequencer.sv
// Plays a five-hit clave pattern against an external bar counter.
module clave_sequencer
    import clave_pkg::*;
#(
    parameter int unsigned       TICK_DIV = 5000,
    parameter int unsigned       CNT_W    = 13,
    parameter logic [CNT_W-1:0]  BAR_LEN  = CNT_W'(BAR_LEN_DEFAULT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [7:0]       num_bars,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_clear,
    output logic             cnt_en,
    output logic             beat,
    output logic [2:0]       beat_idx,
    output logic             bar_done,
    output logic             done,
    output logic [7:0]       bars_played,
    output logic             busy
);

    state_t     state_q, state_d;
    logic [7:0] num_bars_q, num_bars_d;
    logic [7:0] bars_played_q, bars_played_d;
    logic [2:0] beat_ptr_q, beat_ptr_d;
    logic       cnt_clear_q, cnt_clear_d;
    logic       cnt_en_q, cnt_en_d;
    logic       beat_q, beat_d;
    logic [2:0] beat_idx_q, beat_idx_d;
    logic       bar_done_q, bar_done_d;
    logic       done_q, done_d;

    logic       presc_clear;
    logic       presc_run;
    logic       tick;
    logic [7:0] bp_inc;
    logic       beat_hit;

    // The prescaler only advances in RUN cycles that stay in RUN, so a pause
    // freezes it at the exact phase where the request was sampled.
    assign presc_clear = (state_q == ST_CLEAR);
    assign presc_run   = (state_q == ST_RUN) && !pause && !stop;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .run   (presc_run),
        .tick  (tick)
    );

    assign bp_inc   = (bars_played_q == 8'hFF) ? 8'hFF : bars_played_q + 8'd1;
    assign beat_hit = ((state_q == ST_RUN) || (state_q == ST_HOLD))
                   && (beat_ptr_q < 3'(NUM_BEATS))
                   && (cnt_value == CNT_W'(beat_pos(beat_ptr_q)));

    // Next-state and registered-output decode; stop overrides everything last.
    always_comb begin
        state_d       = state_q;
        num_bars_d    = num_bars_q;
        bars_played_d = bars_played_q;
        beat_ptr_d    = beat_ptr_q;
        beat_idx_d    = beat_idx_q;
        cnt_clear_d   = 1'b0;
        cnt_en_d      = 1'b0;
        beat_d        = 1'b0;
        bar_done_d    = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d       = ST_CLEAR;
                    num_bars_d    = num_bars;
                    bars_played_d = '0;
                    cnt_clear_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d    = ST_RUN;
                beat_ptr_d = '0;
            end
            ST_RUN: begin
                if (cnt_value == BAR_LEN) begin
                    state_d       = ST_WRAP;
                    bar_done_d    = 1'b1;
                    bars_played_d = bp_inc;
                    done_d        = (num_bars_q != 8'd0) && (bp_inc == num_bars_q);
                end else if (pause) begin
                    state_d = ST_HOLD;
                end
                cnt_en_d = tick && (cnt_value < BAR_LEN);
            end
            ST_HOLD: begin
                if (!pause) state_d = ST_RUN;
            end
            ST_WRAP: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_CLEAR;
                    cnt_clear_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (beat_hit) begin
            beat_d     = 1'b1;
            beat_idx_d = beat_ptr_q;
            beat_ptr_d = beat_ptr_q + 3'd1;
        end

        if (stop && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            bars_played_d = bars_played_q;
            cnt_clear_d   = 1'b0;
            cnt_en_d      = 1'b0;
            beat_d        = 1'b0;
            bar_done_d    = 1'b0;
            done_d        = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            num_bars_q    <= '0;
            bars_played_q <= '0;
            beat_ptr_q    <= '0;
            cnt_clear_q   <= 1'b0;
            cnt_en_q      <= 1'b0;
            beat_q        <= 1'b0;
            beat_idx_q    <= '0;
            bar_done_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_bars_q    <= num_bars_d;
            bars_played_q <= bars_played_d;
            beat_ptr_q    <= beat_ptr_d;
            cnt_clear_q   <= cnt_clear_d;
            cnt_en_q      <= cnt_en_d;
            beat_q        <= beat_d;
            beat_idx_q    <= beat_idx_d;
            bar_done_q    <= bar_done_d;
            done_q        <= done_d;
        end
    end

    assign cnt_clear   = cnt_clear_q;
    assign cnt_en      = cnt_en_q;
    assign beat        = beat_q;
    assign beat_idx    = beat_idx_q;
    assign bar_done    = bar_done_q;
    assign done        = done_q;
    assign bars_played = bars_played_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clave_sequencer.sv
// Scoreboard bench for clave_sequencer with behavioural external counters.
module tb_clave_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default bar length.
    logic        rst, start, stop, pause;
    logic [7:0]  num_bars;
    logic [12:0] cnt_value = '0;
    logic        cnt_clear, cnt_en, beat, bar_done, done, busy;
    logic [2:0]  beat_idx;
    logic [7:0]  bars_played;

    // Short-bar instance for long loop and reset-in-WRAP runs.
    logic        rst2, start2, stop2, pause2;
    logic [7:0]  num_bars2;
    logic [12:0] cnt_value2 = '0;
    logic        cnt_clear2, cnt_en2, beat2, bar_done2, done2, busy2;
    logic [2:0]  beat_idx2;
    logic [7:0]  bars_played2;

    clave_sequencer #(.TICK_DIV(2)) dut (
        .clk(clk), .reset(rst), .start(start), .stop(stop), .pause(pause),
        .num_bars(num_bars), .cnt_value(cnt_value), .cnt_clear(cnt_clear),
        .cnt_en(cnt_en), .beat(beat), .beat_idx(beat_idx), .bar_done(bar_done),
        .done(done), .bars_played(bars_played), .busy(busy)
    );

    clave_sequencer #(.TICK_DIV(2), .BAR_LEN(13'd4)) dut2 (
        .clk(clk), .reset(rst2), .start(start2), .stop(stop2), .pause(pause2),
        .num_bars(num_bars2), .cnt_value(cnt_value2), .cnt_clear(cnt_clear2),
        .cnt_en(cnt_en2), .beat(beat2), .beat_idx(beat_idx2), .bar_done(bar_done2),
        .done(done2), .bars_played(bars_played2), .busy(busy2)
    );

    // External counters.
    always @(posedge clk) begin
        if (cnt_clear) cnt_value <= '0;
        else           cnt_value <= cnt_value + {12'd0, cnt_en};
        if (cnt_clear2) cnt_value2 <= '0;
        else            cnt_value2 <= cnt_value2 + {12'd0, cnt_en2};
    end

    int tests = 0;
    int fails = 0;
    int clr_seen = 0;

    function automatic void check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    localparam int EV_CLR  = 0;
    localparam int EV_BEAT = 1;
    localparam int EV_BAR  = 2;

    typedef struct {
        int kind;
        int idx;
        int cnt;
        int bp;
        int dn;
    } ev_t;

    ev_t exp_q[$];
    int  pos_tab[5] = '{0, 1200, 2400, 4000, 4800};

    function automatic void push_ev(input int k, input int i, input int c, input int b, input int d);
        ev_t e;
        e.kind = k; e.idx = i; e.cnt = c; e.bp = b; e.dn = d;
        exp_q.push_back(e);
    endfunction

    function automatic void push_bar(input int bp, input int dn, input int nbeats, input bit with_bar);
        push_ev(EV_CLR, 0, 0, 0, 0);
        for (int i = 0; i < nbeats; i++) push_ev(EV_BEAT, i, pos_tab[i], 0, 0);
        if (with_bar) push_ev(EV_BAR, 0, 6600, bp, dn);
    endfunction

    // Monitor: every output pulse of the main instance must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (cnt_clear) begin
                clr_seen++;
                check("clr_en_overlap", int'(cnt_en), 0);
                if (exp_q.size() == 0) check("unexpected_clr", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("clr_kind", e.kind, EV_CLR);
                end
            end
            if (beat) begin
                if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("beat_kind", e.kind, EV_BEAT);
                    check("beat_idx", int'(beat_idx), e.idx);
                    check("beat_cnt", int'(cnt_value), e.cnt);
                end
            end
            if (bar_done) begin
                if (exp_q.size() == 0) check("unexpected_bar_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("bar_kind", e.kind, EV_BAR);
                    check("bar_cnt", int'(cnt_value), e.cnt);
                    check("bar_bars_played", int'(bars_played), e.bp);
                    check("bar_done_flag", int'(done), e.dn);
                end
            end
            if (done && !bar_done) check("done_without_bar_done", 1, 0);
        end
    end

    task automatic wait_cnt(input int v, input int bound, input string name);
        int n = 0;
        while (int'(cnt_value) != v && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(cnt_value), v);
    endtask

    task automatic wait_done(input int bound, input string name);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(done), 1);
    endtask

    task automatic pulse_start(input logic [7:0] nb);
        num_bars = nb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int en_seen, bars, dn, n, bts;
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; num_bars = '0;
        rst2 = 1'b1; start2 = 1'b0; stop2 = 1'b0; pause2 = 1'b0; num_bars2 = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy", int'(busy), 0);
        check("rst_pulses", int'({cnt_clear, cnt_en, beat, bar_done, done}), 0);
        check("rst_bars_played", int'(bars_played), 0);
        check("rst_beat_idx", int'(beat_idx), 0);
        rst = 1'b0;
        @(negedge clk);

        // One bar.
        clr_seen = 0;
        push_bar(1, 1, 5, 1'b1);
        pulse_start(8'd1);
        check("t1_busy", int'(busy), 1);
        wait_done(20000, "t1_done");
        check("t1_bar_with_done", int'(bar_done), 1);
        @(negedge clk);
        check("t1_busy_after", int'(busy), 0);
        check("t1_clr_count", clr_seen, 1);
        check("t1_queue_empty", exp_q.size(), 0);

        // Three bars with a pause at count 2000 in the first bar.
        clr_seen = 0;
        push_bar(1, 0, 5, 1'b1);
        push_bar(2, 0, 5, 1'b1);
        push_bar(3, 1, 5, 1'b1);
        pulse_start(8'd3);
        wait_cnt(2000, 8000, "t2_reach_2000");
        pause = 1'b1;
        en_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (cnt_en) en_seen++;
        end
        pause = 1'b0;
        check("t2_hold_no_en", en_seen, 0);
        check("t2_hold_cnt", int'(cnt_value), 2000);
        @(negedge clk);
        check("t2_resume_early_en", int'(cnt_en), 0);
        @(negedge clk);
        check("t2_resume_phase_en", int'(cnt_en), 1);
        wait_done(45000, "t2_done");
        @(negedge clk);
        check("t2_busy_after", int'(busy), 0);
        check("t2_bars_played", int'(bars_played), 3);
        check("t2_clr_count", clr_seen, 3);
        check("t2_queue_empty", exp_q.size(), 0);

        // start with stop in IDLE is rejected.
        start = 1'b1; stop = 1'b1; num_bars = 8'd1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("t3_startstop_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("t3_startstop_idle", int'(busy), 0);

        // stop mid-bar at count 3000.
        push_bar(0, 0, 3, 1'b0);
        pulse_start(8'd1);
        wait_cnt(3000, 8000, "t3_reach_3000");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t3_stop_busy", int'(busy), 0);
        dn = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("t3_no_done", dn, 0);
        check("t3_cnt_frozen", int'(cnt_value), 3000);
        check("t3_queue_empty", exp_q.size(), 0);

        // Short-bar instance: loop forever, saturation of bars_played.
        rst2 = 1'b0;
        @(negedge clk);
        num_bars2 = 8'd0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        bars = 0; dn = 0; n = 0;
        while (bars < 260 && n < 8000) begin
            @(negedge clk);
            n++;
            if (bar_done2) begin
                bars++;
                if (bars == 254) check("t4_bp_254", int'(bars_played2), 254);
                if (bars == 256) check("t4_bp_256_sat", int'(bars_played2), 255);
            end
            if (done2) dn++;
        end
        check("t4_bars", bars, 260);
        check("t4_no_done", dn, 0);
        check("t4_saturated", int'(bars_played2), 255);
        stop2 = 1'b1;
        @(negedge clk);
        stop2 = 1'b0;
        check("t4_stop_busy", int'(busy2), 0);

        // Reset during WRAP, then a clean one-bar run.
        num_bars2 = 8'd2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!bar_done2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_wrap", int'(bar_done2), 1);
        rst2 = 1'b1;
        @(negedge clk);
        check("t5_rst_busy", int'(busy2), 0);
        check("t5_rst_pulses", int'({cnt_clear2, cnt_en2, beat2, bar_done2, done2}), 0);
        check("t5_rst_bp_idx", int'({bars_played2, beat_idx2}), 0);
        rst2 = 1'b0;
        @(negedge clk);
        num_bars2 = 8'd1;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0; bts = 0;
        while (!done2 && n < 200) begin
            @(negedge clk);
            n++;
            if (beat2) begin
                bts++;
                check("t5_beat_idx", int'(beat_idx2), 0);
            end
        end
        check("t5_done", int'(done2), 1);
        check("t5_bar_with_done", int'(bar_done2), 1);
        check("t5_bars_played", int'(bars_played2), 1);
        check("t5_beats", bts, 1);
        @(negedge clk);
        check("t5_busy_after", int'(busy2), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
